aes_cipher_iter: RTL
====================

# aes_cipher_iter

Iterative AES encryption core that consumes the expanded key schedule produced by the key-expansion stage and turns one 128-bit plaintext block into ciphertext. It performs one round per clock: the initial AddRoundKey on the capture edge, then `nr` rounds. It sits directly downstream of key expansion and upstream of the system's output/mode logic.

## Interface
- `nr`, default 10: number of rounds. Use 10, 12 or 14 for AES-128/192/256. Sets the width of `w`.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request to encrypt `data_in`. Accepted only when `busy`=0.
- `data_in` input [0:127]: plaintext. Bit 0 is the MSB. Byte n is bits [8n:8n+7] and maps to state row n%4, column n/4 (FIPS-197 order).
- `w` input [0:128*(nr+1)-1]: expanded key. Round key r is `w[128r +: 128]`. It is not latched and must stay stable from the accepting edge until `out_valid` rises.
- `data_out` output [0:127]: ciphertext, same byte order as `data_in`. Reset value 0.
- `busy` output 1: rounds are in progress. Reset value 0.
- `out_valid` output 1: `data_out` holds a completed result. Reset value 0.

## Operation
- The FSM has two states, IDLE and RUN. `busy` = (state == RUN).
- A 4-bit round counter `rnd` exists. Its reset value is 0.
- IDLE with `start`=1 at an edge:
  - state register ← `data_in ^ w[0:127]`
  - `rnd` ← 1
  - go to RUN
  - `out_valid` ← 0
- IDLE with `start`=0: everything holds, including `out_valid` and `data_out`.
- RUN, each edge:
  - state ← round(state, `w[128*rnd +: 128]`, final = (`rnd` == nr)).
  - A normal round is SubBytes, ShiftRows, MixColumns, then AddRoundKey.
  - The final round omits MixColumns.
  - `rnd` increments.
- RUN on the edge where `rnd` == nr:
  - `data_out` ← round result
  - `out_valid` ← 1
  - go to IDLE
  - `rnd` ← 0
- `start` while `busy`=1 is ignored. This includes the completing edge, and no request is queued.
- `start` while `out_valid`=1 and IDLE is accepted. `out_valid` drops on that edge and `data_out` holds its old value until overwritten.
- `data_in` is sampled only on the accepting edge and may change afterwards.
- `rst` asserted at any time, including mid-RUN:
  - returns to IDLE immediately
  - clears state, `rnd`, `data_out`, `busy` and `out_valid`
  - the in-flight block is discarded
- Arithmetic:
  - MixColumns uses GF(2^8) with polynomial 0x11B. `xtime(b)` = (b<<1) ^ (b[MSB] ? 0x1B : 0).
  - ShiftRows rotates row r left by r columns.

## Timing
- Accepting edge E0. Rounds run on E1..E(nr).
- `out_valid` and `data_out` are valid after E(nr). For nr=10 that is 10 cycles after E0.
- Throughput is one block per nr+1 cycles. The earliest re-start is the edge after E(nr).
- `busy` rises after E0 and falls after E(nr).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `aes_pkg` holds:
  - the S-box function (256-entry constant table, shared with key expansion)
  - `xtime`
  - `STATE_W`=128
  - the FSM state encoding
- Sub-module `aes_round`: a combinational single round with inputs `state_in`, `round_key` and `final`, and output `state_out`. The core instantiates it once.
- The top level holds only the FSM, the counter, the round-key mux and the registers.

## Test plan
- FIPS-197 C.1 (nr=10):
  - Key 000102030405060708090a0b0c0d0e0f, expanded by the key stage.
  - Plaintext 00112233445566778899aabbccddeeff.
  - Required: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, with `out_valid` exactly 10 cycles after the accepting edge.
- FIPS-197 Appendix B:
  - Key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32. The state after E0 equals 193de3bea0f4e22b9ac68d2ae9f84808.
- Hold `start` high continuously:
  - Required: a new block is accepted only on the edge after each completion.
  - Required: `busy` and `out_valid` never overlap, and each result matches the reference ciphertext.
- Pulse `start` at E3 of a running block, then change `data_in`:
  - Required: the start pulse is ignored.
  - Required: the result equals the original block's ciphertext, because `data_in` was sampled only at E0.
- Assert `rst` at E5 of a run:
  - Required: `busy`, `out_valid` and `data_out` are 0 immediately, without waiting for an edge.
  - Required: a fresh `start` after release produces the correct C.1 result with full latency.
- nr=14, FIPS-197 C.3:
  - Key 000102…1e1f, plaintext 00112233445566778899aabbccddeeff.
  - Required: ciphertext 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions.
//   STATE_W  - width of one AES block / round key in bits
//   fsm_e    - two-state encoding for the iterative cipher core
//   sbox()   - forward S-box lookup (table also used by key expansion)
//   xtime()  - multiply by x in GF(2^8) modulo 0x11B
package aes_pkg;

    localparam int STATE_W = 128;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES encryption round.
//   state_in    - current state, bit 0 = MSB, byte n at [8n +: 8]
//   round_key   - round key applied by AddRoundKey
//   final_round - 1 skips MixColumns (last round)
//   state_out   - SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey
// Byte n sits at row n%4, column n/4, so ShiftRows output (r,c) reads
// input (r, (c+r)%4). Each column is processed by one generate slice.
module aes_round
    import aes_pkg::*;
(
    input  logic [0:STATE_W-1] state_in,
    input  logic [0:STATE_W-1] round_key,
    input  logic               final_round,
    output logic [0:STATE_W-1] state_out
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a [4];
        logic [7:0] m [4];

        // SubBytes fused with ShiftRows: pick the source byte per row
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign a[r] = sbox(state_in[8*(r + 4*((c + r) % 4)) +: 8]);
        end

        // MixColumns matrix rows: {2 3 1 1}, {1 2 3 1}, {1 1 2 3}, {3 1 1 2}
        assign m[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
        assign m[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
        assign m[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
        assign m[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);

        for (genvar r = 0; r < 4; r++) begin : g_ark
            assign state_out[8*(r + 4*c) +: 8] =
                (final_round ? a[r] : m[r]) ^ round_key[8*(r + 4*c) +: 8];
        end
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryption core, one round per clock.
//   nr        - number of rounds (10/12/14), sizes the key schedule input
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   start     - encrypt data_in; only taken while idle
//   data_in   - plaintext, bit 0 = MSB, FIPS-197 byte order
//   w         - expanded key, round key r at w[128r +: 128]; must stay
//               stable from the accepting edge until out_valid rises
//   data_out  - ciphertext of the last completed block
//   busy      - rounds in progress
//   out_valid - data_out holds a completed result
// The accepting edge performs the initial AddRoundKey; rounds 1..nr follow
// on the next nr edges, so a result appears nr cycles after acceptance.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int nr = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [0:STATE_W-1]       data_in,
    input  logic [0:128*(nr+1)-1]    w,
    output logic [0:STATE_W-1]       data_out,
    output logic                     busy,
    output logic                     out_valid
);

    fsm_e               fsm, fsm_nxt;
    logic [3:0]         rnd, rnd_nxt;
    logic [0:STATE_W-1] st, st_nxt;
    logic [0:STATE_W-1] dout_nxt;
    logic               ov_nxt;
    logic [0:STATE_W-1] rk;
    logic [0:STATE_W-1] rnd_res;
    logic               last;

    assign last = (rnd == 4'(nr));
    assign busy = (fsm == ST_RUN);

    // Round-key select from the unlatched schedule
    always_comb begin
        rk = '0;
        for (int r = 0; r <= nr; r++) begin
            if (rnd == 4'(r)) rk = w[128*r +: 128];
        end
    end

    aes_round u_round (
        .state_in    (st),
        .round_key   (rk),
        .final_round (last),
        .state_out   (rnd_res)
    );

    always_comb begin
        fsm_nxt  = fsm;
        rnd_nxt  = rnd;
        st_nxt   = st;
        dout_nxt = data_out;
        ov_nxt   = out_valid;
        case (fsm)
            ST_IDLE: begin
                if (start) begin
                    st_nxt  = data_in ^ w[0:STATE_W-1];
                    rnd_nxt = 4'd1;
                    ov_nxt  = 1'b0;
                    fsm_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                st_nxt  = rnd_res;
                rnd_nxt = rnd + 4'd1;
                // start is deliberately not looked at here, not even on
                // the completing edge: restart needs one idle edge
                if (last) begin
                    dout_nxt = rnd_res;
                    ov_nxt   = 1'b1;
                    rnd_nxt  = 4'd0;
                    fsm_nxt  = ST_IDLE;
                end
            end
            default: fsm_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= ST_IDLE;
            rnd       <= 4'd0;
            st        <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            fsm       <= fsm_nxt;
            rnd       <= rnd_nxt;
            st        <= st_nxt;
            data_out  <= dout_nxt;
            out_valid <= ov_nxt;
        end
    end

endmodule
